// File: rtl/max_seq_ctrl.sv
// Packet maximum finder: keeps the running unsigned max and its position, comparing
// each new word against the max one nibble per cycle (LSB first) through a 4-bit slice.
module max_seq_ctrl #(
  parameter int W  = 16,
  parameter int IW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_max,
  output logic [IW-1:0] out_idx
);

  localparam int NIB = W / 4;
  localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [NW-1:0] NIB_LAST = NW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, CMP, UPD, OUT} state_t;

  state_t        state_q, state_d;
  logic          first_q, first_d;
  logic [W-1:0]  max_q, max_d;
  logic [W-1:0]  op_q, op_d;
  logic [IW-1:0] best_idx_q, best_idx_d;
  logic [IW-1:0] pos_q, pos_d;
  logic [NW-1:0] nib_q, nib_d;
  logic          gt_q, gt_d;
  logic          lst_q, lst_d;

  logic [NW+1:0] sh;
  logic [3:0]    a_nib, b_nib;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      first_q    <= 1'b1;
      max_q      <= '0;
      op_q       <= '0;
      best_idx_q <= '0;
      pos_q      <= '0;
      nib_q      <= '0;
      gt_q       <= 1'b0;
      lst_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      max_q      <= max_d;
      op_q       <= op_d;
      best_idx_q <= best_idx_d;
      pos_q      <= pos_d;
      nib_q      <= nib_d;
      gt_q       <= gt_d;
      lst_q      <= lst_d;
    end
  end

  always_comb begin
    sh    = {nib_q, 2'b00};
    a_nib = op_q[sh +: 4];
    b_nib = max_q[sh +: 4];
  end

  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    max_d      = max_q;
    op_d       = op_q;
    best_idx_d = best_idx_q;
    pos_d      = pos_q;
    nib_d      = nib_q;
    gt_d       = gt_q;
    lst_d      = lst_q;
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == OUT);
    out_max    = max_q;
    out_idx    = best_idx_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (first_q) begin
            max_d      = in_data;
            best_idx_d = '0;
            pos_d      = IW'(1);
            if (in_last) state_d = OUT;
            else         first_d = 1'b0;
          end else begin
            op_d    = in_data;
            lst_d   = in_last;
            nib_d   = '0;
            gt_d    = 1'b0;
            state_d = CMP;
          end
        end
      end
      CMP: begin
        // Higher nibbles are seen later, so they override any lower-nibble verdict.
        gt_d  = (a_nib > b_nib) | ((a_nib == b_nib) & gt_q);
        nib_d = nib_q + 1'b1;
        if (nib_q == NIB_LAST) state_d = UPD;
      end
      UPD: begin
        if (gt_q) begin
          max_d      = op_q;
          best_idx_d = pos_q;
        end
        pos_d   = pos_q + 1'b1;
        state_d = lst_q ? OUT : IDLE;
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
          first_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_max_seq_ctrl.sv
// Bench for max_seq_ctrl: packet-level reference model checked every cycle, plus
// directed packets with literal expected max/index/latency.
module tb_max_seq_ctrl;

  localparam int W   = 16;
  localparam int IW  = 8;
  localparam int NIB = W / 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_max;
  logic [IW-1:0] out_idx;

  int total = 0;
  int bad   = 0;

  max_seq_ctrl #(.W(W), .IW(IW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_max  (out_max),
    .out_idx  (out_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Packet-level model: words collected per packet, max/position found by a plain scan.
  logic [W-1:0]  pkt_q[$];
  logic          m_rdy, m_vld, m_last;
  int            m_cnt;
  logic [W-1:0]  m_max;
  logic [IW-1:0] m_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q.delete();
      m_rdy = 1'b1; m_vld = 1'b0; m_last = 1'b0; m_cnt = 0;
      m_max = '0;   m_idx = '0;
    end else if (m_vld) begin
      if (out_ready) begin m_vld = 1'b0; m_rdy = 1'b1; end
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        if (m_last) m_vld = 1'b1;
        else        m_rdy = 1'b1;
      end
    end else if (m_rdy && in_valid) begin
      pkt_q.push_back(in_data);
      if (pkt_q.size() > 1) begin
        m_cnt = NIB + 1; m_rdy = 1'b0; m_last = in_last;
      end else if (in_last) begin
        m_rdy = 1'b0; m_vld = 1'b1;
      end
      if (in_last) begin
        int bi;
        logic [W-1:0] bm;
        bm = pkt_q[0]; bi = 0;
        for (int i = 1; i < pkt_q.size(); i++)
          if (pkt_q[i] > bm) begin bm = pkt_q[i]; bi = i; end
        m_max = bm;
        m_idx = bi[IW-1:0];
        pkt_q.delete();
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, m_rdy);
    chk("out_valid", out_valid, m_vld);
    if (m_vld || !rst_n) begin
      chk("out_max", out_max, m_max);
      chk("out_idx", out_idx, m_idx);
    end
  end

  task automatic send_word(input logic [W-1:0] d, input logic l);
    int n;
    logic acc;
    n = 0; acc = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_data  = W'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic wait_res(input string nm, input logic [W-1:0] em, input logic [IW-1:0] ei,
                          input int elat);
    int n;
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, n, elat);
    chk({nm, "_max"}, out_max, em);
    chk({nm, "_idx"}, out_idx, ei);
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_max", out_max, 0);
    chk("rst_out_idx", out_idx, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_word(16'h0012, 0); send_word(16'h00A0, 0); send_word(16'h0034, 1);
    wait_res("basic", 16'h00A0, 8'd1, 6);

    send_word(16'hBEEF, 1);
    wait_res("single", 16'hBEEF, 8'd0, 1);

    send_word(16'h1234, 0); send_word(16'h1234, 0); send_word(16'h1235, 1);
    wait_res("lownib", 16'h1235, 8'd2, 6);

    send_word(16'h5555, 0); send_word(16'h5555, 1);
    wait_res("tie", 16'h5555, 8'd0, 6);

    send_word(16'h0F00, 0); send_word(16'h10FF, 1);
    wait_res("chain", 16'h10FF, 8'd1, 6);

    send_word(16'hFFFF, 0); send_word(16'h0000, 0); send_word(16'hFFFE, 1);
    wait_res("edges", 16'hFFFF, 8'd0, 6);

    out_ready = 1'b0;
    send_word(16'h0007, 1);
    wait_res("bp", 16'h0007, 8'd0, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_hold_vld", out_valid, 1);
      chk("bp_hold_max", out_max, 16'h0007);
      chk("bp_hold_rdy", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_after_vld", out_valid, 0);
    chk("bp_after_rdy", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    send_word(16'h0100, 0); send_word(16'h0200, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", out_valid, 0);
    chk("mid_rst_rdy", in_ready, 1);
    chk("mid_rst_max", out_max, 0);
    chk("mid_rst_idx", out_idx, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_word(16'h0003, 1);
    wait_res("post_rst", 16'h0003, 8'd0, 1);

    // 258-word packet: largest word at position 257 reports index 257 mod 256.
    for (int i = 0; i < 258; i++)
      send_word((i == 257) ? 16'h0005 : 16'h0001, (i == 257));
    wait_res("wrap", 16'h0005, 8'd1, 6);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
